// File: rtl/weight_fifo_pkg.sv
// Shared types and sizing helpers for the weight FIFO fill/drain controllers.
package weight_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    LOADED = 2'd2
  } state_t;

  localparam int unsigned DEF_FIFO_WIDTH = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 16;

  // Counter width for n positions; a single position still needs one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_fifo_in_ctrl_if.sv
// Control/handshake bundle between the upstream weight source, the FIFO write side and the drain side.
interface weight_fifo_in_ctrl_if
  import weight_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
);

  logic                          load;
  logic                          abort;
  logic                          in_valid;
  logic                          in_ready;
  logic [FIFO_WIDTH-1:0]         w_wen;
  logic [cnt_w(FIFO_DEPTH)-1:0]  w_row;
  logic                          loaded;
  logic                          drain_done;

  modport master (
    output load, abort, in_valid, drain_done,
    input  in_ready, w_wen, w_row, loaded
  );

  modport slave (
    input  load, abort, in_valid, drain_done,
    output in_ready, w_wen, w_row, loaded
  );

endinterface

// File: rtl/weight_fifo_rc_cnt.sv
// Row-major lane/row position counter shared by the FIFO fill and drain controllers.
module weight_fifo_rc_cnt
  import weight_fifo_pkg::*;
#(
  parameter int unsigned LANES = DEF_FIFO_WIDTH,
  parameter int unsigned ROWS  = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      en,
  output logic [cnt_w(LANES)-1:0]   lane,
  output logic [cnt_w(ROWS)-1:0]    row,
  output logic                      lane_wrap,
  output logic                      row_wrap
);

  localparam int unsigned LW = cnt_w(LANES);
  localparam int unsigned RW = cnt_w(ROWS);

  assign lane_wrap = (lane == LW'(LANES - 1));
  assign row_wrap  = (row  == RW'(ROWS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane <= '0;
      row  <= '0;
    end else if (en) begin
      if (lane_wrap) begin
        lane <= '0;
        row  <= row_wrap ? '0 : row + RW'(1);
      end else begin
        lane <= lane + LW'(1);
      end
    end
  end

endmodule

// File: rtl/weight_fifo_in_ctrl.sv
// Write-side controller: fills every lane of the weight FIFO bank row-major, then holds until drained.
module weight_fifo_in_ctrl
  import weight_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  weight_fifo_in_ctrl_if.slave bus
);

  localparam int unsigned LW = cnt_w(FIFO_WIDTH);
  localparam int unsigned RW = cnt_w(FIFO_DEPTH);

  state_t                state, state_nxt;
  logic                  ready;
  logic                  accept;
  logic                  cnt_clear;
  logic [LW-1:0]         lane_cnt;
  logic [RW-1:0]         row_cnt;
  logic                  lane_wrap, row_wrap;
  logic [FIFO_WIDTH-1:0] wen;
  logic [RW-1:0]         row_out;

  // Counters only advance while filling; any other state or an abort parks them at lane 0, row 0.
  assign cnt_clear = (state != FILL) || bus.abort;

  weight_fifo_rc_cnt #(
    .LANES (FIFO_WIDTH),
    .ROWS  (FIFO_DEPTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .en        (accept),
    .lane      (lane_cnt),
    .row       (row_cnt),
    .lane_wrap (lane_wrap),
    .row_wrap  (row_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.load && !bus.abort)         state_nxt = FILL;
      FILL:    if (bus.abort)                      state_nxt = IDLE;
               else if (accept && lane_wrap && row_wrap) state_nxt = LOADED;
      LOADED:  if (bus.drain_done)                 state_nxt = IDLE;
      default:                                     state_nxt = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of the registered state.
  always_comb begin
    ready   = (state == FILL) && !rst;
    accept  = ready && bus.in_valid;
    wen     = '0;
    row_out = '0;
    if (accept) begin
      wen     = FIFO_WIDTH'(1) << lane_cnt;
      row_out = row_cnt;
    end
  end

  assign bus.in_ready = ready;
  assign bus.w_wen    = wen;
  assign bus.w_row    = row_out;
  assign bus.loaded   = (state == LOADED) && !rst;

endmodule

// File: tb/tb_weight_fifo_in_ctrl.sv
// Directed table-driven bench for weight_fifo_in_ctrl with 4 lanes x 4 rows.
module tb_weight_fifo_in_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  weight_fifo_in_ctrl_if #(.FIFO_WIDTH(4), .FIFO_DEPTH(4)) bus ();

  weight_fifo_in_ctrl #(.FIFO_WIDTH(4), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       load;
    logic       abort;
    logic       vld;
    logic       dd;
    logic       ir;
    logic [3:0] wen;
    logic [1:0] row;
    logic       ld;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic l, input logic a, input logic v,
                              input logic d, input logic ir, input logic [3:0] wen,
                              input logic [1:0] row, input logic ld);
    vq.push_back('{r, l, a, v, d, ir, wen, row, ld});
  endfunction

  // One cycle: drive on the falling edge, let outputs settle, return before the next rising edge.
  task automatic cyc(input logic r, input logic l, input logic a, input logic v, input logic d);
    @(negedge clk);
    rst            = r;
    bus.load       = l;
    bus.abort      = a;
    bus.in_valid   = v;
    bus.drain_done = d;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ir, input logic [3:0] wen,
                            input logic [1:0] row, input logic ld);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'(ir));
    check({tag, " w_wen"},    32'(bus.w_wen),    32'(wen));
    check({tag, " w_row"},    32'(bus.w_row),    32'(row));
    check({tag, " loaded"},   32'(bus.loaded),   32'(ld));
  endtask

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.drain_done = 1'b0;

    // reset with other inputs active, then idle-state corner cases
    add(1, 1, 0, 1, 0,  0, 4'b0000, 2'd0, 0);
    add(1, 1, 0, 1, 0,  0, 4'b0000, 2'd0, 0);
    add(0, 1, 1, 0, 0,  0, 4'b0000, 2'd0, 0);   // load+abort in IDLE: stays IDLE
    add(0, 0, 0, 1, 1,  0, 4'b0000, 2'd0, 0);   // drain_done/in_valid in IDLE: no effect
    add(0, 0, 0, 0, 0,  0, 4'b0000, 2'd0, 0);
    add(0, 1, 0, 0, 0,  0, 4'b0000, 2'd0, 0);   // load -> FILL next cycle
    add(0, 1, 0, 0, 1,  1, 4'b0000, 2'd0, 0);   // drain_done/load in FILL ignored
    // toggled in_valid fill: exactly 16 pulses, none on idle beats
    for (int k = 0; k < 16; k++) begin
      add(0, 0, 0, 1, 0,  1, 4'(1 << (k % 4)), 2'(k / 4), 0);
      if (k < 15) add(0, 0, 0, 0, 0,  1, 4'b0000, 2'd0, 0);
    end
    add(0, 0, 0, 1, 0,  0, 4'b0000, 2'd0, 1);   // LOADED the cycle after beat 16
    add(0, 1, 1, 1, 0,  0, 4'b0000, 2'd0, 1);   // load/abort ignored in LOADED
    add(0, 1, 0, 0, 1,  0, 4'b0000, 2'd0, 1);   // drain_done with load: load ignored
    add(0, 0, 0, 1, 0,  0, 4'b0000, 2'd0, 0);   // back in IDLE
    add(0, 1, 0, 0, 0,  0, 4'b0000, 2'd0, 0);   // refill
    for (int k = 0; k < 16; k++)
      add(0, 0, 0, 1, 0,  1, 4'(1 << (k % 4)), 2'(k / 4), 0);
    add(0, 0, 0, 1, 0,  0, 4'b0000, 2'd0, 1);
    add(0, 0, 0, 0, 1,  0, 4'b0000, 2'd0, 1);
    add(0, 0, 0, 0, 0,  0, 4'b0000, 2'd0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].rst, vq[i].load, vq[i].abort, vq[i].vld, vq[i].dd);
      check_outs($sformatf("vec%0d", i), vq[i].ir, vq[i].wen, vq[i].row, vq[i].ld);
    end

    // abort after 6 beats; the beat in the abort cycle is still written
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    check_outs("abort_beat", 1, 4'b0100, 2'd1, 0);
    cyc(0, 0, 0, 1, 0);
    check_outs("after_abort", 0, 4'b0000, 2'd0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 0, 1, 0);
      if (k == 0) check_outs("restart_first", 1, 4'b0001, 2'd0, 0);
      if (k == 15) check_outs("restart_last", 1, 4'b1000, 2'd3, 0);
    end
    cyc(0, 0, 0, 0, 0);
    check_outs("restart_loaded", 0, 4'b0000, 2'd0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    check_outs("drained", 0, 4'b0000, 2'd0, 0);

    // reset mid-fill after 9 beats with in_valid held high
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 9; k++) cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    check_outs("rst_mid0", 0, 4'b0000, 2'd0, 0);
    cyc(1, 1, 0, 1, 0);
    check_outs("rst_mid1", 0, 4'b0000, 2'd0, 0);
    cyc(0, 0, 0, 1, 0);
    check_outs("rst_release", 0, 4'b0000, 2'd0, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check_outs("rst_refill", 1, 4'b0001, 2'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_fifo_in_ctrl.md
WEIGHT_FIFO_IN_CTRL -- requirements
Module: weight_fifo_in_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, number of weight FIFO lanes.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, entries per lane.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port load, input, 1, a level-sampled request to begin filling all lanes.
REQ-006 SHALL have port abort, input, 1, which cancels an in-progress fill.
REQ-007 SHALL have port in_valid, input, 1, meaning the upstream weight beat is valid.
REQ-008 SHALL have port in_ready, output, 1, meaning this block accepts a beat.
REQ-009 SHALL have port w_wen, output, FIFO_WIDTH, a one-hot per-lane FIFO write enable.
REQ-010 SHALL have port w_row, output, $clog2(FIFO_DEPTH) max 1, the row index being written.
REQ-011 SHALL have port loaded, output, 1, meaning all lanes are full and ready to drain.
REQ-012 SHALL have port drain_done, input, 1, the single-cycle done pulse from the read-side controller.

Function
REQ-013 SHALL implement three states: IDLE, FILL and LOADED.
REQ-014 IDLE -> FILL SHALL occur when load=1 and abort=0; lane_cnt and row_cnt are cleared on entry.
REQ-015 in_ready SHALL be 1 only in FILL (combinational from state) and 0 in IDLE and LOADED.
REQ-016 A beat SHALL be accepted only when in_valid && in_ready; in_valid with in_ready=0 has no effect.
REQ-017 On an accepted beat, w_wen SHALL be 1<<lane_cnt and w_row = row_cnt in the same cycle (zero latency); otherwise w_wen = 0.
REQ-018 Fill order SHALL be row-major: lane_cnt increments per accepted beat; at lane FIFO_WIDTH-1 it wraps to 0 and row_cnt increments.
REQ-019 The beat at lane FIFO_WIDTH-1, row FIFO_DEPTH-1 SHALL move the state to LOADED, with counters cleared, after exactly FIFO_WIDTH*FIFO_DEPTH accepted beats.
REQ-020 loaded SHALL be 1 exactly while in LOADED (registered state decode), starting the cycle after the last beat.
REQ-021 LOADED -> IDLE SHALL occur on drain_done=1; load in the same cycle is ignored, so re-fill needs load asserted in IDLE.
REQ-022 drain_done SHALL be ignored in IDLE and FILL.
REQ-023 load SHALL be ignored in FILL and LOADED.
REQ-024 abort in FILL SHALL return to IDLE next cycle with counters cleared; a beat accepted in that same cycle is still written (w_wen pulses).
REQ-025 abort SHALL be ignored in LOADED, and in IDLE abort SHALL take priority over load (stays IDLE).
REQ-026 Counters SHALL never exceed FIFO_WIDTH-1 / FIFO_DEPTH-1; no arithmetic overflow is permitted.
REQ-027 Stalls (in_valid=0) of any length mid-fill SHALL hold counters and state unchanged.

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE and lane_cnt=row_cnt=0, overriding all other inputs including mid-fill.
REQ-029 While rst=1, outputs SHALL be in_ready=0, w_wen=0, w_row=0 and loaded=0.

Structure
REQ-030 The state enum (IDLE/FILL/LOADED) SHALL live in shared package weight_fifo_pkg alongside the lane/row count-width constants used by both fifo controllers.
REQ-031 The lane/row counter pair SHALL be a sub-module, weight_fifo_rc_cnt (enable, clear, wrap outputs), reusable by the read side.
REQ-032 No data path SHALL pass through this block; data goes to the FIFOs directly, qualified by w_wen.

Verification (FIFO_WIDTH=4, FIFO_DEPTH=4)
REQ-033 Scenario: load pulse, then 16 beats with in_valid=1 -> w_wen sequence 0001,0010,0100,1000 per row; w_row 0..3; loaded=1 the cycle after beat 16; in_ready=0 afterward.
REQ-034 Scenario: fill with in_valid toggling 1/0 -> still exactly 16 w_wen pulses, and no pulse while in_valid=0.
REQ-035 Scenario: loaded, then drain_done pulse -> IDLE next cycle with loaded=0; a second load then refills from lane 0, row 0.
REQ-036 Scenario: abort after 6 beats -> IDLE; a new load restarts at w_wen=0001, w_row=0, and loaded needs 16 further beats.
REQ-037 Scenario: rst asserted after 9 beats with in_valid held 1 -> in_ready=0 and w_wen=0 while rst=1, and state is IDLE after release.
REQ-038 Scenario: load+abort together in IDLE, and drain_done in FILL -> no state change in either case.
